// File: rtl/dbg_instr_injector_pkg.sv
// Shared definitions for the debug instruction injector: the NOP used to
// drain the pipeline and the injector state encoding.
package dbg_inject_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FLUSH
  } inj_state_t;

endpackage

// File: rtl/dbg_instr_injector_if.sv
// Debugger-to-injector program-load channel: a valid/ready word stream
// that fills the program buffer while the core is halted.
interface dbg_instr_injector_if;

  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/dbg_instr_injector_prog_buf.sv
// Program buffer: DEPTH x 32 register file, one synchronous write port and
// one combinational read port. Storage is deliberately not reset so a loaded
// program only costs the write port, never a reset tree.
module dbg_prog_buf #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Store an accepted debugger word at the write address.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dbg_instr_injector.sv
// Debug-mode instruction source. While idle the fetch stream passes through
// and the debugger may load the program buffer. On an accepted go the
// buffered words replace the fetch stream, followed by DRAIN_CYCLES NOPs and
// a single flush cycle before the fetch path is handed back.
module dbg_instr_injector
  import dbg_inject_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset_stages,
  dbg_instr_injector_if.slave        wr,
  input  logic                       clear,
  input  logic                       go,
  input  logic                       core_halted,
  input  logic                       stall,
  input  logic [31:0]                fetch_instr,
  output logic [31:0]                instr_out,
  output logic                       inject_active,
  output logic                       flush_stages,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  inj_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          err_q, err_d;
  logic          buf_we;
  logic          wr_ready_int;
  logic [31:0]   buf_rd;

  dbg_prog_buf #(.DEPTH(DEPTH)) u_prog_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (count_q[PW-1:0]),
    .wr_data (wr.wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (buf_rd)
  );

  // Next-state, counter updates and output mux; an abort (core leaving
  // halt) takes precedence over normal progress so the pipeline is flushed.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    drain_d       = drain_q;
    err_d         = err_q;
    buf_we        = 1'b0;
    wr_ready_int  = 1'b0;
    instr_out     = fetch_instr;
    inject_active = 1'b0;
    flush_stages  = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready_int = (count_q < CW'(DEPTH));
        buf_we       = wr.wr_valid && wr_ready_int && !clear;
        if (clear)       count_d = '0;
        else if (buf_we) count_d = count_q + CW'(1);
        if (go && core_halted && (count_d != '0)) begin
          rd_ptr_d = '0;
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        inject_active = 1'b1;
        instr_out     = buf_rd;
        if (!core_halted) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (!stall) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (CW'(rd_ptr_q) == count_q - CW'(1)) begin
            drain_d = DW'(DRAIN_CYCLES);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        inject_active = 1'b1;
        instr_out     = NOP_INSTR;
        if (!core_halted) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (!stall) begin
          drain_d = drain_q - DW'(1);
          if (drain_q == DW'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        inject_active = 1'b1;
        instr_out     = NOP_INSTR;
        flush_stages  = 1'b1;
        done          = !err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_stages) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
    end
  end

  assign wr.wr_ready = wr_ready_int;
  assign err         = err_q;
  assign count       = count_q;

endmodule

// File: doc/dbg_instr_injector.md
# dbg_instr_injector

Debug-mode instruction source for the pipeline's instruction-register stages. The external debugger loads a short program into an internal program buffer while the core is halted; on `go` the block replaces the fetch stream with those instructions, one per non-stalled cycle. It then pads with NOPs to drain the pipeline and pulses `flush_stages` into the IR stages' flush input before handing the fetch path back.

## Interface
- `DEPTH`, 8, number of program-buffer entries; power of two, ≥2.
- `DRAIN_CYCLES`, 3, number of NOPs issued after the last buffered instruction; ≥1.
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset_stages`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  debugger presents a program word.
- `wr_data`  in  32  program word.
- `wr_ready`  out  1  the word is accepted when `wr_valid && wr_ready`.
- `clear`  in  1  empties the program buffer (IDLE only).
- `go`  in  1  start request.
- `core_halted`  in  1  core is in debug halt.
- `stall`  in  1  pipeline stall; the current `instr_out` is held.
- `fetch_instr`  in  32  normal fetch-path instruction.
- `instr_out`  out  32  to the first IR stage input.
- `inject_active`  out  1  high in ISSUE, DRAIN and FLUSH; freezes the PC and selects the injected path.
- `flush_stages`  out  1  single-cycle flush pulse to the IR stages.
- `done`  out  1  single-cycle pulse; the program completed normally.
- `err`  out  1  sticky flag; the run was aborted. Cleared by the next accepted `go` or by reset.
- `count`  out  $clog2(DEPTH+1)  number of valid buffer entries.

## Operation
- States are IDLE, ISSUE, DRAIN and FLUSH.
- IDLE:
  - `instr_out = fetch_instr` (combinational pass-through).
  - `wr_ready = (count < DEPTH)`. In every other state `wr_ready` is 0.
  - An accepted write stores to `buf[count]` and increments `count`.
  - `clear` sets `count` to 0 and has priority over a write in the same cycle.
- `go` is accepted only in IDLE with `core_halted=1` and the post-cycle count ≥1. Otherwise it is ignored and `err` is unchanged.
  - A write and `go` in the same cycle: the write lands first, so the run includes that word.
  - On acceptance: `rd_ptr` is set to 0, `err` is cleared, and the state becomes ISSUE.
- ISSUE:
  - `instr_out = buf[rd_ptr]`.
  - When `!stall`, `rd_ptr` increments.
  - When `!stall && rd_ptr == count-1`, the state becomes DRAIN and `drain_cnt` is loaded with `DRAIN_CYCLES`.
- DRAIN:
  - `instr_out = NOP_INSTR`.
  - When `!stall`, `drain_cnt` decrements.
  - When `!stall && drain_cnt == 1`, the state becomes FLUSH.
- FLUSH:
  - Lasts exactly one cycle and ignores `stall`.
  - `instr_out = NOP_INSTR`, `flush_stages = 1`, and `done = 1` unless the run is aborting.
  - Next state is IDLE.
- Abort: `core_halted == 0` in ISSUE or DRAIN moves the state to FLUSH on the next edge and sets `err`. The FLUSH cycle then drives `done = 0`.
- Buffer contents and `count` survive a run, so the same program can be re-run with `go`.
- `rd_ptr` is $clog2(DEPTH) bits and never wraps within a run, because the end of the run is detected at `count-1`.

## Timing
- Reset values: IDLE, `count=0`, `rd_ptr=0`, `drain_cnt=0`, `err=0`, `inject_active=0`, `flush_stages=0`, `done=0`, `wr_ready=1`, `instr_out=fetch_instr`. Buffer storage is not reset.
- Reset asserted mid-run returns the block to IDLE on the next edge with no flush pulse.
- `instr_out`, `inject_active` and `wr_ready` are combinational from the registered state. `flush_stages` and `done` are decoded from FLUSH.
- Latency from `go` to the first injected instruction: `go` is sampled at edge k, and `buf[0]` appears on `instr_out` in the cycle following edge k.
- A stall-free run of N instructions: N ISSUE cycles, then `DRAIN_CYCLES` NOP cycles, then 1 FLUSH cycle. `inject_active` is high for N+`DRAIN_CYCLES`+1 cycles.
- Each stalled cycle adds exactly one cycle and repeats the same `instr_out` value.

## Structure
- Package `dbg_inject_pkg` holds:
  - `NOP_INSTR = 32'h00000013`;
  - the state enum `inj_state_t` {IDLE, ISSUE, DRAIN, FLUSH}.
- Sub-module `dbg_prog_buf` holds the buffer: DEPTH×32 register file with one synchronous write port and a combinational read port addressed by `rd_ptr`.
- The FSM, counters and output mux live in the top module.

## Test plan
- Load 3 words (0x00100093, 0x00200113, 0x00308193), `core_halted=1`, pulse `go`, no stalls:
  - `instr_out` shows those 3 words, then 3×0x00000013;
  - `flush_stages=1` and `done=1` on the 7th cycle;
  - IDLE on the 8th cycle, `count=3`.
- Same program with `stall` high for 2 cycles while `buf[1]` is on `instr_out`: 0x00200113 is held for 3 cycles, and `done` arrives 2 cycles later than in the first test.
- Write 8 words (`DEPTH=8`): `wr_ready=0` after the 8th; a 9th `wr_valid` is not accepted and `count` stays 8.
- In DRAIN, drop `core_halted`: next cycle is FLUSH with `flush_stages=1`, `done=0`, `err=1`; a subsequent accepted `go` clears `err`.
- Ignored starts: `go` with `count=0`, and `go` with `core_halted=0`, both leave the block in IDLE with `instr_out=fetch_instr` and `inject_active=0`.
- Assert `reset_stages` mid-ISSUE: IDLE and `count=0` on the next cycle, with no `flush_stages` or `done` pulse.
